// File: rtl/jtframe_ram_fill_if.sv
// jtframe_ram_fill_if: command, stream and RAM write port bundle for jtframe_ram_fill
// master: command source / stream producer / RAM consumer side
// slave : the fill engine (drives din_ready, ram_*, busy, done and optional chk)
// Optional JTFRAME_RAM_FILL_CHK_EN adds the 16-bit chk signal
interface jtframe_ram_fill_if #(parameter int dw = 8, parameter int aw = 10);
   logic          start, clr, abort, din_valid, din_ready, ram_we, busy, done;
   logic [dw-1:0] fill_val, din, ram_data;
   logic [aw-1:0] base, ram_addr;
   logic [aw:0]   len;
`ifdef JTFRAME_RAM_FILL_CHK_EN
   logic [15:0]   chk;
   modport master(output start, clr, fill_val, base, len, abort, din, din_valid,
                  input din_ready, ram_addr, ram_data, ram_we, busy, done, chk);
   modport slave(input start, clr, fill_val, base, len, abort, din, din_valid,
                 output din_ready, ram_addr, ram_data, ram_we, busy, done, chk);
`else
   modport master(output start, clr, fill_val, base, len, abort, din, din_valid,
                  input din_ready, ram_addr, ram_data, ram_we, busy, done);
   modport slave(input start, clr, fill_val, base, len, abort, din, din_valid,
                 output din_ready, ram_addr, ram_data, ram_we, busy, done);
`endif
endinterface

// File: rtl/jtframe_ram_fill.sv
// jtframe_ram_fill: writes a stream (copy) or a constant (clear) into a RAM address window
// clk, rst : single clock, synchronous active-high reset
// bus      : slave side of jtframe_ram_fill_if (command, stream, registered RAM write port, busy/done)
// JTFRAME_RAM_FILL_CHK_EN adds bus.chk, a 16-bit running sum of written data
module jtframe_ram_fill #(parameter int dw = 8, parameter int aw = 10) (
   input logic           clk,
   input logic           rst,
   jtframe_ram_fill_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        r_state, w_next;
   logic          r_clr, r_we, w_wr, w_ready, w_load;
   logic [dw-1:0] r_fill, r_data, w_data;
   logic [aw-1:0] r_cnt, r_addr;
   logic [aw:0]   r_rem;
`ifdef JTFRAME_RAM_FILL_CHK_EN
   logic [15:0]   r_chk;
   assign bus.chk = r_chk;
`endif
   assign bus.din_ready = w_ready;
   assign bus.ram_we    = r_we;
   assign bus.ram_addr  = r_addr;
   assign bus.ram_data  = r_data;
   assign bus.busy      = r_state != IDLE;
   assign bus.done      = r_state == DONE;
   assign w_load        = r_state == IDLE && bus.start;
   assign w_data        = r_clr ? r_fill : bus.din;
   always_ff @(posedge clk)
      r_state <= rst ? IDLE : w_next;
   // abort blocks both the beat handshake and the write of the current cycle
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_wr    = 1'b0;
      case (r_state)
         IDLE: if (bus.start) w_next = bus.len == '0 ? DONE : RUN;
         RUN: begin
            w_ready = !r_clr && !bus.abort;
            w_wr    = !bus.abort && (r_clr || bus.din_valid);
            w_next  = bus.abort ? IDLE : (w_wr && r_rem == (aw+1)'(1)) ? DONE : RUN;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_clr  <= 1'b0;
         r_fill <= '0;
         r_cnt  <= '0;
         r_rem  <= '0;
`ifdef JTFRAME_RAM_FILL_CHK_EN
         r_chk  <= '0;
`endif
      end else begin
         r_we <= w_wr;
         if (w_load) begin
            r_clr  <= bus.clr;
            r_fill <= bus.fill_val;
            r_cnt  <= bus.base;
            r_rem  <= bus.len;
`ifdef JTFRAME_RAM_FILL_CHK_EN
            r_chk  <= '0;
`endif
         end
         if (w_wr) begin
            r_addr <= r_cnt;
            r_data <= w_data;
            r_cnt  <= r_cnt + aw'(1);
            r_rem  <= r_rem - (aw+1)'(1);
`ifdef JTFRAME_RAM_FILL_CHK_EN
            r_chk  <= r_chk + 16'(w_data);
`endif
         end
      end
   end
endmodule

// File: tb/tb_jtframe_ram_fill.sv
// tb_jtframe_ram_fill: directed vector table plus reset and checksum sequences for jtframe_ram_fill
module tb_jtframe_ram_fill;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   jtframe_ram_fill_if #(.dw(8), .aw(10)) bus();
   jtframe_ram_fill #(.dw(8), .aw(10)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic        start, clr;
      logic [7:0]  fill_val;
      logic [9:0]  base;
      logic [10:0] len;
      logic        abort;
      logic [7:0]  din;
      logic        din_valid;
      logic        e_ready, e_we;
      logic [9:0]  e_addr;
      logic [7:0]  e_data;
      logic        e_busy, e_done;
   } vec_t;
   localparam int NV = 23;
   vec_t v[NV];
   function automatic vec_t mk(input logic st, cl, input logic [7:0] fv, input logic [9:0] ba,
                               input logic [10:0] ln, input logic ab, input logic [7:0] di,
                               input logic dv, rdy, we, input logic [9:0] ad,
                               input logic [7:0] da, input logic bs, dn);
      vec_t x;
      x.start = st; x.clr = cl; x.fill_val = fv; x.base = ba; x.len = ln; x.abort = ab;
      x.din = di; x.din_valid = dv; x.e_ready = rdy; x.e_we = we; x.e_addr = ad;
      x.e_data = da; x.e_busy = bs; x.e_done = dn;
      return x;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   task automatic drive(input vec_t x);
      bus.start = x.start; bus.clr = x.clr; bus.fill_val = x.fill_val; bus.base = x.base;
      bus.len = x.len; bus.abort = x.abort; bus.din = x.din; bus.din_valid = x.din_valid;
   endtask
   task automatic idle();
      drive(mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0));
   endtask
   task automatic chk_rst_outputs(input string tag);
      chk({tag, ".we"}, bus.ram_we, 0);
      chk({tag, ".addr"}, bus.ram_addr, 0);
      chk({tag, ".data"}, bus.ram_data, 0);
      chk({tag, ".busy"}, bus.busy, 0);
      chk({tag, ".done"}, bus.done, 0);
      chk({tag, ".ready"}, bus.din_ready, 0);
   endtask
   initial begin
      //        st cl fill   base     len    ab din    dv  rdy we addr     data   bsy dn
      v[0]  = mk(1, 1, 8'hA5, 10'h3FE, 11'd4, 0, 8'h00, 0,  0, 0, 10'h000, 8'h00, 1, 0);
      v[1]  = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h00, 0,  0, 1, 10'h3FE, 8'hA5, 1, 0);
      v[2]  = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h00, 1,  0, 1, 10'h3FF, 8'hA5, 1, 0);
      v[3]  = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h00, 0,  0, 1, 10'h000, 8'hA5, 1, 0);
      v[4]  = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h00, 0,  0, 1, 10'h001, 8'hA5, 1, 1);
      v[5]  = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h00, 0,  0, 0, 10'h000, 8'h00, 0, 0);
      v[6]  = mk(1, 0, 8'h00, 10'h100, 11'd3, 0, 8'h00, 0,  0, 0, 10'h000, 8'h00, 1, 0);
      v[7]  = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h11, 1,  1, 1, 10'h100, 8'h11, 1, 0);
      v[8]  = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h99, 0,  1, 0, 10'h000, 8'h00, 1, 0);
      v[9]  = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h22, 1,  1, 1, 10'h101, 8'h22, 1, 0);
      v[10] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h99, 0,  1, 0, 10'h000, 8'h00, 1, 0);
      v[11] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h33, 1,  1, 1, 10'h102, 8'h33, 1, 1);
      v[12] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h44, 1,  0, 0, 10'h000, 8'h00, 0, 0);
      v[13] = mk(1, 1, 8'h77, 10'h010, 11'd0, 0, 8'h00, 0,  0, 0, 10'h000, 8'h00, 1, 1);
      v[14] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h00, 0,  0, 0, 10'h000, 8'h00, 0, 0);
      v[15] = mk(1, 0, 8'h00, 10'h200, 11'd8, 0, 8'h00, 0,  0, 0, 10'h000, 8'h00, 1, 0);
      v[16] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h41, 1,  1, 1, 10'h200, 8'h41, 1, 0);
      v[17] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h42, 1,  1, 1, 10'h201, 8'h42, 1, 0);
      v[18] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h43, 1,  1, 1, 10'h202, 8'h43, 1, 0);
      v[19] = mk(0, 0, 8'h00, 10'h000, 11'd0, 1, 8'h44, 1,  0, 0, 10'h000, 8'h00, 0, 0);
      v[20] = mk(1, 0, 8'h00, 10'h050, 11'd1, 1, 8'h00, 0,  0, 0, 10'h000, 8'h00, 1, 0);
      v[21] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h55, 1,  1, 1, 10'h050, 8'h55, 1, 1);
      v[22] = mk(0, 0, 8'h00, 10'h000, 11'd0, 0, 8'h00, 0,  0, 0, 10'h000, 8'h00, 0, 0);
      idle();
      repeat (2) @(posedge clk);
      #1 chk_rst_outputs("reset");
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(v[i]);
         #1 chk($sformatf("ready[%0d]", i), bus.din_ready, v[i].e_ready);
         @(posedge clk);
         #1;
         chk($sformatf("we[%0d]", i), bus.ram_we, v[i].e_we);
         chk($sformatf("busy[%0d]", i), bus.busy, v[i].e_busy);
         chk($sformatf("done[%0d]", i), bus.done, v[i].e_done);
         if (v[i].e_we) begin
            chk($sformatf("addr[%0d]", i), bus.ram_addr, v[i].e_addr);
            chk($sformatf("data[%0d]", i), bus.ram_data, v[i].e_data);
         end
      end
      // long clear interrupted by reset; start pulses while busy must not disturb it
      @(negedge clk);
      bus.start = 1; bus.clr = 1; bus.fill_val = 8'h3C; bus.base = 10'h000; bus.len = 11'd100;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.start = 1; bus.clr = 0; bus.fill_val = 8'hEE; bus.base = 10'h300 + 10'(k); bus.len = 11'(k);
         @(posedge clk);
         #1;
         chk($sformatf("mid.we[%0d]", k), bus.ram_we, 1);
         chk($sformatf("mid.addr[%0d]", k), bus.ram_addr, k);
         chk($sformatf("mid.data[%0d]", k), bus.ram_data, 8'h3C);
      end
      @(negedge clk);
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1 chk_rst_outputs("midrst");
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post.we[%0d]", k), bus.ram_we, 0);
         chk($sformatf("post.busy[%0d]", k), bus.busy, 0);
      end
`ifdef JTFRAME_RAM_FILL_CHK_EN
      @(negedge clk);
      bus.start = 1; bus.clr = 0; bus.base = 10'h020; bus.len = 11'd3;
      @(negedge clk);
      bus.start = 0; bus.din = 8'hFF; bus.din_valid = 1;
      repeat (3) @(negedge clk);
      idle();
      repeat (2) @(posedge clk);
      #1 chk("chk.copy", bus.chk, 16'h02FD);
      @(negedge clk);
      bus.start = 1; bus.clr = 1; bus.fill_val = 8'h01; bus.base = 10'h030; bus.len = 11'd2;
      @(posedge clk);
      #1 chk("chk.clear_at_start", bus.chk, 16'h0000);
      @(negedge clk) idle();
      repeat (4) @(posedge clk);
      #1 chk("chk.fill", bus.chk, 16'h0002);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
